// File: rtl/pc_sequencer.sv
// Purpose: program-counter sequencer; owns the ROM PC, the program select, and run/cycle/retire bookkeeping.
// Latency: all outputs registered; a redirect decoded while pc_out=p shows on pc_out one cycle later.
// Backpressure: no handshake; stall holds the PC and suppresses retirement, halt_req still ends the run.
module pc_sequencer #(
  parameter int PC_WIDTH  = 16,
  parameter int PROG_LEN  = 127,
  parameter int NUM_PROGS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          prog_sel,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch_taken,
  input  logic [7:0]          branch_offset,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [1:0]          rom_sel,
  output logic                instr_valid,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         cycle_count,
  output logic [31:0]         instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Parameter values sized to the buses they are compared against.
  localparam logic [PC_WIDTH-1:0] PROG_LEN_PC  = PC_WIDTH'(PROG_LEN);
  localparam logic [2:0]          NUM_PROGS_W  = 3'(NUM_PROGS);
  localparam logic [31:0]         COUNT_MAX    = 32'hFFFF_FFFF;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [1:0]          rom_sel_nxt;
  logic [31:0]         cycle_nxt;
  logic [31:0]         instr_nxt;

  // Candidate next PCs; all arithmetic wraps modulo 2^PC_WIDTH so a
  // backwards branch past 0 lands at a huge value and fails the range check.
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] br_pc;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                redirect_ok;
  logic                prog_ok;
  logic [31:0]         cycle_inc;
  logic [31:0]         instr_inc;

  assign seq_pc      = pc_out + PC_WIDTH'(1);
  assign br_pc       = pc_out + {{(PC_WIDTH-8){branch_offset[7]}}, branch_offset};
  assign redirect_pc = jump ? jump_target : (branch_taken ? br_pc : seq_pc);
  assign redirect_ok = (redirect_pc < PROG_LEN_PC);
  assign prog_ok     = ({1'b0, prog_sel} < NUM_PROGS_W);

  // Counters stick at all-ones rather than wrapping.
  assign cycle_inc = (cycle_count == COUNT_MAX) ? cycle_count : cycle_count + 32'd1;
  assign instr_inc = (instr_count == COUNT_MAX) ? instr_count : instr_count + 32'd1;

  // Status flags are pure decodes of the state register.
  assign busy        = (state == S_RUN);
  assign instr_valid = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign err         = (state == S_ERR);

  // Next-state, next-PC and counter update; everything holds by default.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_out;
    rom_sel_nxt = rom_sel;
    cycle_nxt   = cycle_count;
    instr_nxt   = instr_count;

    case (state)
      S_RUN: begin
        // Every RUN cycle counts; only non-stalled ones retire.
        cycle_nxt = cycle_inc;
        if (!stall) begin
          instr_nxt = instr_inc;
        end

        if (halt_req) begin
          // Halt wins over everything, even a stall; PC stays on the halt.
          state_nxt = S_DONE;
        end else if (!stall) begin
          if (redirect_ok) begin
            pc_nxt = redirect_pc;
          end else begin
            // Leave pc_out on the instruction that tried to leave the ROM.
            state_nxt = S_ERR;
          end
        end
      end

      default: begin
        // IDLE, DONE and ERR all wait for start; a bad select still clears
        // the counters but leaves the ROM mux where it was.
        if (start) begin
          cycle_nxt = 32'd0;
          instr_nxt = 32'd0;
          if (prog_ok) begin
            state_nxt   = S_RUN;
            pc_nxt      = '0;
            rom_sel_nxt = prog_sel;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, program select and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out      <= '0;
      rom_sel     <= 2'd0;
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      pc_out      <= pc_nxt;
      rom_sel     <= rom_sel_nxt;
      cycle_count <= cycle_nxt;
      instr_count <= instr_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors, a rule-level reference model, and
// a negedge compare process, plus literal expectations at key points.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  prog_sel;
  logic        stall;
  logic        halt_req;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [7:0]  branch_offset;
  logic [15:0] pc_out;
  logic [1:0]  rom_sel;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  pc_sequencer #(.PC_WIDTH(16), .PROG_LEN(127), .NUM_PROGS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
    .stall(stall), .halt_req(halt_req), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc_out(pc_out), .rom_sel(rom_sel), .instr_valid(instr_valid), .busy(busy),
    .done(done), .err(err), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase names, not RTL encodings.
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;
  int          m_phase;
  logic [15:0] m_pc;
  logic [1:0]  m_rom;
  logic [31:0] m_cyc;
  logic [31:0] m_ins;

  int n_vec;
  int n_bad;
  bit chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    m_pc    = 16'd0;
    m_rom   = 2'd0;
    m_cyc   = 32'd0;
    m_ins   = 32'd0;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, advance one edge.
  task automatic step(input logic st, input logic [1:0] ps, input logic stl,
                      input logic hlt, input logic jmp, input logic [15:0] jt,
                      input logic br, input logic [7:0] off);
    int          n_phase;
    logic [15:0] n_pc;
    logic [1:0]  n_rom;
    logic [31:0] n_cyc;
    logic [31:0] n_ins;
    int          t;
    start = st; prog_sel = ps; stall = stl; halt_req = hlt;
    jump = jmp; jump_target = jt; branch_taken = br; branch_offset = off;
    n_phase = m_phase; n_pc = m_pc; n_rom = m_rom; n_cyc = m_cyc; n_ins = m_ins;
    if (reset) begin
      n_phase = M_IDLE; n_pc = 16'd0; n_rom = 2'd0; n_cyc = 32'd0; n_ins = 32'd0;
    end else if (m_phase != M_RUN) begin
      if (st) begin
        n_cyc = 32'd0;
        n_ins = 32'd0;
        if (int'(ps) < 3) begin
          n_phase = M_RUN; n_pc = 16'd0; n_rom = ps;
        end else begin
          n_phase = M_ERR;
        end
      end
    end else begin
      n_cyc = sat_inc(m_cyc);
      if (!stl) n_ins = sat_inc(m_ins);
      if (hlt) begin
        n_phase = M_DONE;
      end else if (!stl) begin
        if (jmp)     t = int'(jt);
        else if (br) t = (int'(m_pc) + int'($signed(off))) & 32'h0000_FFFF;
        else         t = (int'(m_pc) + 1) & 32'h0000_FFFF;
        if (t >= 127) n_phase = M_ERR;
        else          n_pc = t[15:0];
      end
    end
    @(posedge clk);
    #1;
    m_phase = n_phase; m_pc = n_pc; m_rom = n_rom; m_cyc = n_cyc; m_ins = n_ins;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0);
  endtask

  task automatic go(input logic [1:0] ps);
    step(1'b1, ps, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0);
  endtask

  task automatic jmp_to(input logic [15:0] t);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, t, 1'b0, 8'd0);
  endtask

  task automatic br_by(input logic [7:0] off);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, off);
  endtask

  // Single compare process: whole output set against the model every negedge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out",      32'(pc_out),      32'(m_pc));
      chk("rom_sel",     32'(rom_sel),     32'(m_rom));
      chk("busy",        32'(busy),        32'(m_phase == M_RUN));
      chk("instr_valid", 32'(instr_valid), 32'(m_phase == M_RUN));
      chk("done",        32'(done),        32'(m_phase == M_DONE));
      chk("err",         32'(err),         32'(m_phase == M_ERR));
      chk("cycle_count", cycle_count,      m_cyc);
      chk("instr_count", instr_count,      m_ins);
    end
  end

  initial begin
    n_vec = 0; n_bad = 0; chk_en = 1'b0;
    reset = 1'b1; start = 1'b0; prog_sel = 2'd0; stall = 1'b0; halt_req = 1'b0;
    jump = 1'b0; jump_target = 16'd0; branch_taken = 1'b0; branch_offset = 8'd0;
    model_reset();
    #12;
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_rom", 32'(rom_sel), 32'd0);
    chk("rst_flags", 32'({instr_valid, busy, done, err}), 32'd0);
    chk("rst_cnt", cycle_count | instr_count, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Straight-line run of program 2.
    go(2'd2);
    chk("start_pc", 32'(pc_out), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    nop(5);
    chk("seq_pc", 32'(pc_out), 32'd5);
    chk("seq_instr", instr_count, 32'd5);
    chk("seq_rom", 32'(rom_sel), 32'd2);

    // Branches backwards to 0 and forwards to 15 from PC 10.
    nop(5);
    chk("at10", 32'(pc_out), 32'd10);
    br_by(8'hF6);
    chk("br_neg", 32'(pc_out), 32'd0);
    nop(10);
    br_by(8'h05);
    chk("br_pos", 32'(pc_out), 32'd15);

    // Stall beats jump for three cycles at PC 7.
    jmp_to(16'd7);
    chk("jmp7", 32'(pc_out), 32'd7);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd40, 1'b0, 8'd0);
      chk("stall_pc", 32'(pc_out), 32'd7);
    end
    nop(1);
    chk("after_stall", 32'(pc_out), 32'd8);
    chk("stall_gap", cycle_count - instr_count, 32'd3);

    // start while running is ignored.
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0);
    chk("start_in_run", 32'({rom_sel, pc_out}), {14'd0, 2'd2, 16'd9});

    // Backwards branch past 0 is an error; PC stays put.
    jmp_to(16'd2);
    br_by(8'hFD);
    chk("wrap_err", 32'(err), 32'd1);
    chk("wrap_pc", 32'(pc_out), 32'd2);

    // Halt at the last legal PC, then restart.
    go(2'd0);
    chk("restart_cnt", cycle_count, 32'd0);
    jmp_to(16'd126);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 8'd0);
    chk("halt_done", 32'({done, busy}), 32'b10);
    chk("halt_pc", 32'(pc_out), 32'd126);
    chk("halt_instr", instr_count, 32'd2);
    nop(2);
    go(2'd0);
    chk("rerun", 32'({done, busy, pc_out}), {14'd0, 2'b01, 16'd0});

    // Fall-through off the end of the ROM, then a bad program select.
    jmp_to(16'd126);
    nop(1);
    chk("fall_err", 32'(err), 32'd1);
    chk("fall_pc", 32'(pc_out), 32'd126);
    go(2'd3);
    chk("bad_sel_err", 32'(err), 32'd1);
    chk("bad_sel_cnt", cycle_count | instr_count, 32'd0);
    chk("bad_sel_rom", 32'(rom_sel), 32'd0);

    // Halt under stall ends the run without retiring.
    go(2'd1);
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 8'd0);
    chk("stall_halt_done", 32'(done), 32'd1);
    chk("stall_halt_cnt", {cycle_count[15:0], instr_count[15:0]}, {16'd1, 16'd0});

    // Jump beyond the ROM.
    go(2'd1);
    jmp_to(16'd200);
    chk("jmp_oor_err", 32'(err), 32'd1);
    chk("jmp_oor_pc", 32'(pc_out), 32'd0);

    // Asynchronous reset in the middle of a RUN cycle.
    go(2'd2);
    nop(3);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_pc", 32'(pc_out), 32'd0);
    chk("arst_rom", 32'(rom_sel), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", cycle_count | instr_count, 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd50, 1'b0, 8'd0);
    reset = 1'b0;
    nop(3);
    chk("idle_hold", 32'({busy, pc_out}), 32'd0);
    go(2'd1);
    chk("post_rst_run", 32'({busy, rom_sel, pc_out}), {13'd0, 1'b1, 2'd1, 16'd0});
    nop(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
